// File: rtl/amo_sequencer.sv
// rtl/amo_sequencer.sv - RV32A atomic sequencer (AMO*.W, LR.W, SC.W) for the MA stage
// Runs read/modify/write for one atomic at a time and holds the single LR/SC reservation.
module amo_sequencer #(
   parameter int XLEN = 32
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_amo_valid,
   input  logic [4:0]      i_amo_funct5,
   input  logic [XLEN-1:0] i_amo_address,
   input  logic [XLEN-1:0] i_amo_operand,
   input  logic            i_flush,
   input  logic [XLEN-1:0] i_mem_read_data,
   input  logic            i_snoop_write,
   input  logic [XLEN-1:0] i_snoop_address,
   output logic            o_stall,
   output logic            o_mem_read_enable,
   output logic [XLEN-1:0] o_mem_read_address,
   output logic            o_amo_write_enable,
   output logic [XLEN-1:0] o_amo_write_address,
   output logic [XLEN-1:0] o_amo_write_data,
   output logic            o_rd_valid,
   output logic [XLEN-1:0] o_rd_data
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_READ    = 3'd1;
   localparam logic [2:0] S_CAPTURE = 3'd2;
   localparam logic [2:0] S_WRITE   = 3'd3;
   localparam logic [2:0] S_DONE    = 3'd4;

   localparam logic [4:0] F_ADD  = 5'b00000;
   localparam logic [4:0] F_SWAP = 5'b00001;
   localparam logic [4:0] F_LR   = 5'b00010;
   localparam logic [4:0] F_SC   = 5'b00011;
   localparam logic [4:0] F_XOR  = 5'b00100;
   localparam logic [4:0] F_OR   = 5'b01000;
   localparam logic [4:0] F_AND  = 5'b01100;
   localparam logic [4:0] F_MIN  = 5'b10000;
   localparam logic [4:0] F_MAX  = 5'b10100;
   localparam logic [4:0] F_MINU = 5'b11000;
   localparam logic [4:0] F_MAXU = 5'b11100;

   logic [2:0]      state;
   logic [4:0]      op_q;
   logic [XLEN-1:0] addr_q;
   logic [XLEN-1:0] operand_q;
   logic [XLEN-1:0] wdata_q;
   logic [XLEN-1:0] rd_q;
   logic            res_valid;
   logic [XLEN-3:0] res_word;
   logic [XLEN-1:0] new_val;
   logic            op_writes;
   logic            accept;
   logic            in_is_sc;
   logic            sc_ok;
   logic            snoop_hit;
   logic            own_write_hit;
   logic            unused_bits;

   assign unused_bits = ^{i_amo_address[1:0], i_snoop_address[1:0]};

   assign accept        = (state == S_IDLE) && i_amo_valid && !i_flush;
   assign in_is_sc      = (i_amo_funct5 == F_SC);
   assign sc_ok         = res_valid && (res_word == i_amo_address[XLEN-1:2]);
   assign snoop_hit     = i_snoop_write && (res_word == i_snoop_address[XLEN-1:2]);
   assign own_write_hit = (state == S_WRITE) && (res_word == addr_q[XLEN-1:2]);

   always_comb begin
      new_val   = i_mem_read_data;
      op_writes = 1'b1;
      case (op_q)
         F_ADD:   new_val = i_mem_read_data + operand_q;
         F_SWAP:  new_val = operand_q;
         F_XOR:   new_val = i_mem_read_data ^ operand_q;
         F_OR:    new_val = i_mem_read_data | operand_q;
         F_AND:   new_val = i_mem_read_data & operand_q;
         F_MIN:   new_val = ($signed(i_mem_read_data) < $signed(operand_q)) ? i_mem_read_data : operand_q;
         F_MAX:   new_val = ($signed(i_mem_read_data) > $signed(operand_q)) ? i_mem_read_data : operand_q;
         F_MINU:  new_val = (i_mem_read_data < operand_q) ? i_mem_read_data : operand_q;
         F_MAXU:  new_val = (i_mem_read_data > operand_q) ? i_mem_read_data : operand_q;
         default: op_writes = 1'b0;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state     <= S_IDLE;
         op_q      <= '0;
         addr_q    <= '0;
         operand_q <= '0;
         wdata_q   <= '0;
         rd_q      <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  op_q      <= i_amo_funct5;
                  addr_q    <= {i_amo_address[XLEN-1:2], 2'b00};
                  operand_q <= i_amo_operand;
                  if (in_is_sc) begin
                     // SC never touches memory for its read; status is known at accept
                     if (sc_ok) begin
                        wdata_q <= i_amo_operand;
                        rd_q    <= '0;
                        state   <= S_WRITE;
                     end else begin
                        rd_q  <= XLEN'(1);
                        state <= S_DONE;
                     end
                  end else begin
                     state <= S_READ;
                  end
               end
            end
            S_READ: state <= i_flush ? S_IDLE : S_CAPTURE;
            S_CAPTURE: begin
               if (i_flush) begin
                  state <= S_IDLE;
               end else begin
                  rd_q    <= i_mem_read_data;
                  wdata_q <= new_val;
                  state   <= op_writes ? S_WRITE : S_DONE;
               end
            end
            S_WRITE: state <= S_DONE;
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // An LR completing its read beats a same-cycle snoop: the load is already ordered
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         res_valid <= 1'b0;
         res_word  <= '0;
      end else if ((state == S_CAPTURE) && !i_flush && (op_q == F_LR)) begin
         res_valid <= 1'b1;
         res_word  <= addr_q[XLEN-1:2];
      end else if ((accept && in_is_sc) || snoop_hit || own_write_hit) begin
         res_valid <= 1'b0;
      end
   end

   assign o_stall             = accept || (state == S_READ) || (state == S_CAPTURE) || (state == S_WRITE);
   assign o_mem_read_enable   = (state == S_READ);
   assign o_mem_read_address  = addr_q;
   assign o_amo_write_enable  = (state == S_WRITE);
   assign o_amo_write_address = addr_q;
   assign o_amo_write_data    = wdata_q;
   assign o_rd_valid          = (state == S_DONE);
   assign o_rd_data           = rd_q;

endmodule
